// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the riscv32 five-stage pipeline.
//
// Consumes the ID/EX register outputs and computes ALU, shift, address and
// link results. It resolves branches and jumps, which produces a one-cycle
// flush/redirect pulse. It runs an iterative 32-cycle shift-add multiplier
// for MUL/MULH/MULHSU/MULHU. Results land in an EX/MEM output bank.
//
// Handshake (both sides): a transfer happens on the rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until that edge, and ready never depends on the same-side valid.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   E_instr_valid, in_ready   ID/EX -> EX handshake
//   E_PC, E_recoverPC         instruction PC, alternate PC for a mispredict
//   E_instr_type              one-hot R/I/load/store/branch/JAL/JALR/U
//   E_funct3, E_funct7        opcode qualifiers
//   E_immediate32, E_shamt    immediate, I-type shift amount
//   E_A, E_B, E_rd            rs1/rs2 values, destination register
//   E_BranchTaken, E_islui    fetch prediction, LUI-vs-AUIPC select
//   out_valid, out_ready      EX -> EX/MEM handshake
//   M_*                       EX/MEM output bank
//   flush, redirect_pc        registered one-cycle redirect pulse
//   dbg_state                 FSM state (0 = IDLE, 1 = MUL)
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        E_instr_valid,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_recoverPC,
  input  logic [7:0]  E_instr_type,
  input  logic [2:0]  E_funct3,
  input  logic [6:0]  E_funct7,
  input  logic [31:0] E_immediate32,
  input  logic [4:0]  E_shamt,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [4:0]  E_rd,
  input  logic        E_BranchTaken,
  input  logic        E_islui,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] M_PC,
  output logic [31:0] M_result,
  output logic [31:0] M_store_data,
  output logic [4:0]  M_rd,
  output logic        M_wen,
  output logic [7:0]  M_instr_type,
  output logic [2:0]  M_funct3,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Instruction decode
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_u;
  logic is_muldiv, is_mul;

  assign is_r    = E_instr_type[0];
  assign is_i    = E_instr_type[1];
  assign is_ld   = E_instr_type[2];
  assign is_st   = E_instr_type[3];
  assign is_br   = E_instr_type[4];
  assign is_jal  = E_instr_type[5];
  assign is_jalr = E_instr_type[6];
  assign is_u    = E_instr_type[7];

  assign is_muldiv = is_r && (E_funct7 == 7'b0000001);
  assign is_mul    = is_muldiv && !E_funct3[2];

  // Handshake
  logic bank_free, accept, take;

  assign bank_free = !out_valid || out_ready;
  assign in_ready  = (state_q == S_IDLE) && bank_free;
  assign accept    = E_instr_valid && in_ready;
  // Anything accepted while flush is high is wrong-path and only consumed.
  assign take      = accept && !flush;

  // ALU
  logic [31:0] op_b;
  logic [4:0]  shamt_amt;
  logic [31:0] alu_res;

  assign op_b      = is_r ? E_B : E_immediate32;
  assign shamt_amt = is_r ? E_B[4:0] : E_shamt;

  always_comb begin
    alu_res = 32'd0;
    case (E_funct3)
      3'b000: alu_res = (is_r && E_funct7[5]) ? (E_A - E_B) : (E_A + op_b);
      3'b001: alu_res = E_A << shamt_amt;
      3'b010: alu_res = {31'd0, ($signed(E_A) < $signed(op_b))};
      3'b011: alu_res = {31'd0, (E_A < op_b)};
      3'b100: alu_res = E_A ^ op_b;
      3'b101: alu_res = E_funct7[5] ? 32'($signed(E_A) >>> shamt_amt)
                                    : (E_A >> shamt_amt);
      3'b110: alu_res = E_A | op_b;
      3'b111: alu_res = E_A & op_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Single-cycle result select
  logic [31:0] addr_sum;
  logic [31:0] single_res;

  assign addr_sum = E_A + E_immediate32;

  always_comb begin
    single_res = 32'd0;
    if (is_muldiv)                 single_res = 32'd0;  // div/rem unsupported
    else if (is_r || is_i)         single_res = alu_res;
    else if (is_ld || is_st)       single_res = addr_sum;
    else if (is_jal || is_jalr)    single_res = E_PC + 32'd4;
    else if (is_u)                 single_res = E_islui ? E_immediate32
                                                        : (E_PC + E_immediate32);
    else                           single_res = 32'd0;
  end

  logic wen_d;
  assign wen_d = (is_r || is_i || is_ld || is_jal || is_jalr || is_u) &&
                 (E_rd != 5'd0);

  // Branch resolution
  logic br_taken, set_flush;
  logic [31:0] redir_target;

  always_comb begin
    br_taken = 1'b0;
    case (E_funct3)
      3'b000: br_taken = (E_A == E_B);
      3'b001: br_taken = (E_A != E_B);
      3'b100: br_taken = ($signed(E_A) <  $signed(E_B));
      3'b101: br_taken = ($signed(E_A) >= $signed(E_B));
      3'b110: br_taken = (E_A <  E_B);
      3'b111: br_taken = (E_A >= E_B);
      default: br_taken = 1'b0;
    endcase
  end

  assign set_flush    = take && ((is_br && (br_taken != E_BranchTaken)) || is_jalr);
  assign redir_target = is_jalr ? (addr_sum & ~32'd1) : E_recoverPC;

  // Multiplier: magnitudes are multiplied unsigned, sign applied at the end.
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [31:0] mcand_q;
  logic [63:0] acc_q;
  logic [4:0]  mul_cnt_q;
  logic        mul_neg_q;
  logic [32:0] mul_sum;
  logic [63:0] acc_next;
  logic [63:0] prod_final;
  logic [31:0] mul_word;

  // 000/001 sign both, 010 signs rs1 only, 011 signs neither.
  assign sign_a = (E_funct3[1:0] != 2'b11) && E_A[31];
  assign sign_b = !E_funct3[1] && E_B[31];
  assign mag_a  = sign_a ? (32'd0 - E_A) : E_A;
  assign mag_b  = sign_b ? (32'd0 - E_B) : E_B;

  // acc holds {partial product, remaining multiplier bits}; each step adds
  // the multiplicand into the upper half when the low bit is set, then
  // shifts the whole thing right, keeping the carry.
  assign mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign acc_next   = {mul_sum, acc_q[31:1]};
  assign prod_final = mul_neg_q ? (64'd0 - acc_next) : acc_next;
  assign mul_word   = (M_funct3 == 3'b000) ? prod_final[31:0] : prod_final[63:32];

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_cnt_q == 5'd31) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = (state_q == S_MUL);

  // Datapath and output bank
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      M_PC         <= 32'd0;
      M_result     <= 32'd0;
      M_store_data <= 32'd0;
      M_rd         <= 5'd0;
      M_wen        <= 1'b0;
      M_instr_type <= 8'd0;
      M_funct3     <= 3'd0;
      flush        <= 1'b0;
      redirect_pc  <= 32'd0;
      mcand_q      <= 32'd0;
      acc_q        <= 64'd0;
      mul_cnt_q    <= 5'd0;
      mul_neg_q    <= 1'b0;
    end else begin
      flush <= set_flush;
      if (set_flush) redirect_pc <= redir_target;

      if (state_q == S_IDLE) begin
        if (bank_free) begin
          if (take) begin
            // Tag fields are loaded now for both paths; a MUL keeps
            // out_valid low until its product is ready.
            M_PC         <= E_PC;
            M_store_data <= E_B;
            M_rd         <= E_rd;
            M_wen        <= wen_d;
            M_instr_type <= E_instr_type;
            M_funct3     <= E_funct3;
            if (is_mul) begin
              out_valid <= 1'b0;
              mcand_q   <= mag_a;
              acc_q     <= {32'd0, mag_b};
              mul_neg_q <= sign_a ^ sign_b;
              mul_cnt_q <= 5'd0;
            end else begin
              out_valid <= 1'b1;
              M_result  <= single_res;
            end
          end else begin
            // Bubble or wrong-path instruction.
            out_valid <= 1'b0;
          end
        end
      end else begin
        acc_q     <= acc_next;
        mul_cnt_q <= mul_cnt_q + 5'd1;
        if (mul_cnt_q == 5'd31) begin
          out_valid <= 1'b1;
          M_result  <= mul_word;
        end
      end
    end
  end

endmodule
